// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, state encoding and round/schedule functions
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int IDX_W = $clog2(ROUNDS);
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_sched_word.sv
// sha256_sched_word: one message-schedule expansion word from W[t-2], W[t-7], W[t-15], W[t-16]
module sha256_sched_word import sha256_pkg::*; (
  input  logic [WORD_W-1:0] w2,
  input  logic [WORD_W-1:0] w7,
  input  logic [WORD_W-1:0] w15,
  input  logic [WORD_W-1:0] w16,
  output logic [WORD_W-1:0] w
);
  assign w = s1(w2) + w7 + s0(w15) + w16;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads 16 words, expands W[0..63], serves W[WI] until RELEASE.
// SHA256_SCHED_RDREG_EN defined: W_OUT registered (1-cycle latency); else combinational.
module sha256_msg_schedule import sha256_pkg::*; (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic [WORD_W-1:0] LOAD_WORD,
  input  logic [IDX_W-1:0]  WI,
  output logic [WORD_W-1:0] W_OUT,
  output logic              DONE,
  input  logic              RELEASE
);
  state_t st, st_nx;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] w [ROUNDS];
  logic [WORD_W-1:0] w_new;
  logic acc, exp_en;
  assign acc = LOAD_VALID && LOAD_READY;
  assign exp_en = st == ST_EXPAND;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) st <= ST_IDLE;
    else st <= st_nx;
  always_comb
    st_nx = (st == ST_IDLE && acc && idx == IDX_W'(15)) ? ST_EXPAND :
            (exp_en && idx == IDX_W'(ROUNDS - 1)) ? ST_DONE :
            (st == ST_DONE && RELEASE) ? ST_IDLE : st;
  always_comb begin
    LOAD_READY = st == ST_IDLE;
    DONE = st == ST_DONE;
  end
  // idx parks at 63 in DONE; only RELEASE (or reset) rewinds it
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) idx <= '0;
    else if (acc || (exp_en && idx != IDX_W'(ROUNDS - 1))) idx <= idx + 1'b1;
    else if (st == ST_DONE && RELEASE) idx <= '0;
  always_ff @(posedge CLK)
    if (acc || exp_en) w[idx] <= exp_en ? w_new : LOAD_WORD;
  sha256_sched_word u_word (
    .w2  (w[idx - IDX_W'(2)]),
    .w7  (w[idx - IDX_W'(7)]),
    .w15 (w[idx - IDX_W'(15)]),
    .w16 (w[idx - IDX_W'(16)]),
    .w   (w_new)
  );
`ifdef SHA256_SCHED_RDREG_EN
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) W_OUT <= '0;
    else W_OUT <= w[WI];
`else
  assign W_OUT = w[WI];
`endif
endmodule
